// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: sequential packed-BCD to binary converter.
//
// Uses the reverse double-dabble method. On each conversion cycle the
// combined {bcd_sr, bin_sr} register shifts right by one bit. Any BCD nibble
// that reads 8 or more after the shift then has 3 subtracted from it. After
// BIN_W cycles, bin_sr holds the binary value.
//
// Optional feature, enabled by defining BCD2BIN_ERR_CHECK_EN:
//   Requests that carry a nibble greater than 9 are rejected in IDLE. A
//   rejection raises a done pulse together with the sticky error flag and
//   leaves binary unchanged. Without the macro, no digit check is made and
//   error stays 0.
//
// Back-to-back operation: the edge that completes a conversion also acts as
// a start-sampling point. A start held through completion therefore reloads
// immediately, and conversions repeat every BIN_W cycles with no idle gap.

module bcd_to_binary_seq #(
    parameter int BCD_DIGITS = 3,
    parameter int BIN_W      = 10
) (
    input  logic                    clk_50MHz,
    input  logic                    reset,
    input  logic                    start,
    input  logic [4*BCD_DIGITS-1:0] bcd_in,
    output logic [BIN_W-1:0]        binary,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    localparam longint DEC_RANGE = pow10(BCD_DIGITS);
    localparam longint BIN_RANGE = longint'(1) << BIN_W;

    // The result width must be able to hold every representable BCD value.
    generate
        if (BIN_RANGE < DEC_RANGE) begin : g_width_check
            $error("bcd_to_binary_seq: BIN_W too small for BCD_DIGITS");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t            state_q;
    logic [BCD_W-1:0]  bcd_sr_q, bcd_sr_d;
    logic [BIN_W-1:0]  bin_sr_q, bin_sr_d;
    logic [BIN_W-1:0]  binary_q;
    logic [CNT_W-1:0]  count_q;
    logic              busy_q, done_q, error_q;

    logic              last_iter;
    logic              sample_pt;
    logic              digit_bad;
    logic              load;
    logic              reject;

    // One shift-and-correct step of the conversion.
    always_comb begin
        logic [BCD_W-1:0] sh;
        sh       = {1'b0, bcd_sr_q[BCD_W-1:1]};
        bin_sr_d = {bcd_sr_q[0], bin_sr_q[BIN_W-1:1]};
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (sh[4*i +: 4] >= 4'd8) begin
                sh[4*i +: 4] = sh[4*i +: 4] - 4'd3;
            end
        end
        bcd_sr_d = sh;
    end

`ifdef BCD2BIN_ERR_CHECK_EN
    // Flag any input nibble outside 0..9.
    always_comb begin
        digit_bad = 1'b0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                digit_bad = 1'b1;
            end
        end
    end
`else
    assign digit_bad = 1'b0;
`endif

    assign last_iter = (state_q == CONV) && (count_q == CNT_W'(BIN_W - 1));
    assign sample_pt = (state_q == IDLE) || last_iter;
    assign load      = sample_pt && start && !digit_bad;
    // A bad request arriving on a completion edge is not rejected there,
    // because its done pulse would merge with the finishing one. It is
    // picked up from IDLE on the following edge instead.
    assign reject    = (state_q == IDLE) && start && digit_bad;

    // Control FSM and datapath registers. Later assignments take precedence,
    // so a reload on the completion edge overrides the return to IDLE.
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            bcd_sr_q <= '0;
            bin_sr_q <= '0;
            binary_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == CONV) begin
                bcd_sr_q <= bcd_sr_d;
                bin_sr_q <= bin_sr_d;
                count_q  <= count_q + CNT_W'(1);
                if (last_iter) begin
                    binary_q <= bin_sr_d;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            end
            if (reject) begin
                error_q <= 1'b1;
                done_q  <= 1'b1;
            end else if (load) begin
                bcd_sr_q <= bcd_in;
                bin_sr_q <= '0;
                count_q  <= '0;
                error_q  <= 1'b0;
                busy_q   <= 1'b1;
                state_q  <= CONV;
            end
        end
    end

    assign binary = binary_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign error  = error_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed testbench for bcd_to_binary_seq (default parameters).

module tb_bcd_to_binary_seq;

    logic        clk_50MHz;
    logic        reset;
    logic        start;
    logic [11:0] bcd_in;
    logic [9:0]  binary;
    logic        busy;
    logic        done;
    logic        error;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_to_binary_seq #(.BCD_DIGITS(3), .BIN_W(10)) dut (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .start     (start),
        .bcd_in    (bcd_in),
        .binary    (binary),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    initial begin
        clk_50MHz = 1'b0;
        forever #10 clk_50MHz = ~clk_50MHz;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: timeout reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50MHz);
        #1;
    endtask

    // Waits for done; reports cycles taken and whether busy dropped early.
    task automatic wait_done(output int cyc, output bit gap);
        cyc = 0;
        gap = 1'b0;
        do begin
            tick();
            cyc++;
            if (!done && !busy) gap = 1'b1;
        end while (!done && cyc < 30);
    endtask

    task automatic run_conv(input logic [11:0] bcd, input logic [9:0] exp, input string tag);
        int cyc;
        bit gap;
        bcd_in = bcd;
        start  = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " busy_at_start"}, 32'(busy), 32'd1);
        wait_done(cyc, gap);
        check({tag, " latency"}, 32'(cyc), 32'd10);
        check({tag, " busy_gap"}, 32'(gap), 32'd0);
        check({tag, " binary"}, 32'(binary), 32'(exp));
        check({tag, " error"}, 32'(error), 32'd0);
        check({tag, " busy_end"}, 32'(busy), 32'd0);
        tick();
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " binary_hold"}, 32'(binary), 32'(exp));
    endtask

    initial begin
        int cyc;
        int extra;
        bit gap;

        // Reset state, with start held high during reset.
        reset  = 1'b0;
        start  = 1'b1;
        bcd_in = 12'h999;
        #25;
        check("rst binary", 32'(binary), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst error", 32'(error), 32'd0);
        tick();
        tick();
        check("rst no_accept", 32'(busy), 32'd0);
        start = 1'b0;
        @(negedge clk_50MHz);
        reset = 1'b1;
        tick();

        run_conv(12'h999, 10'd999, "c999");
        run_conv(12'h001, 10'd1, "c001");
        run_conv(12'h100, 10'd100, "c100");

        // Back-to-back with start held: 000 then 255, dones 10 cycles apart.
        bcd_in = 12'h000;
        start  = 1'b1;
        tick();
        tick();
        bcd_in = 12'h255;
        wait_done(cyc, gap);
        check("b2b first_latency", 32'(cyc + 1), 32'd10);
        check("b2b first_binary", 32'(binary), 32'd0);
        check("b2b busy_stays", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(cyc, gap);
        check("b2b spacing", 32'(cyc), 32'd10);
        check("b2b second_binary", 32'(binary), 32'd255);
        check("b2b gap", 32'(gap), 32'd0);

        // start pulses during a conversion are ignored.
        tick();
        bcd_in = 12'h123;
        start  = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 0;
        do begin
            tick();
            cyc++;
            start = (cyc == 2 || cyc == 6) ? 1'b1 : 1'b0;
            if (cyc == 3) bcd_in = 12'h777;
        end while (!done && cyc < 30);
        start = 1'b0;
        check("ign latency", 32'(cyc), 32'd10);
        check("ign binary", 32'(binary), 32'd123);
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) extra++;
        end
        check("ign extra_done", 32'(extra), 32'd0);
        check("ign busy_idle", 32'(busy), 32'd0);

        // Invalid digit handling.
        bcd_in = 12'h1A5;
        start  = 1'b1;
        tick();
        start = 1'b0;
`ifdef BCD2BIN_ERR_CHECK_EN
        check("bad done", 32'(done), 32'd1);
        check("bad error", 32'(error), 32'd1);
        check("bad busy", 32'(busy), 32'd0);
        check("bad binary_kept", 32'(binary), 32'd123);
        tick();
        check("bad done_one_cycle", 32'(done), 32'd0);
        check("bad error_sticky", 32'(error), 32'd1);
`else
        check("bad busy", 32'(busy), 32'd1);
        wait_done(cyc, gap);
        check("bad latency", 32'(cyc), 32'd10);
        check("bad error", 32'(error), 32'd0);
        tick();
`endif
        run_conv(12'h042, 10'd42, "c042");

        // Asynchronous reset mid-conversion aborts without done.
        bcd_in = 12'h876;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #3;
        reset = 1'b0;
        #1;
        check("arst binary", 32'(binary), 32'd0);
        check("arst busy", 32'(busy), 32'd0);
        check("arst done", 32'(done), 32'd0);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) extra++;
        end
        check("arst no_done", 32'(extra), 32'd0);
        @(negedge clk_50MHz);
        reset = 1'b1;
        tick();
        run_conv(12'h876, 10'd876, "c876");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
